// File: rtl/br_arb_req_stage_if.sv
// rtl/br_arb_req_stage_if.sv - push-side and arbiter-side signal bundle for br_arb_req_stage
interface br_arb_req_stage_if #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned Width         = 8
);
    logic [NumRequesters-1:0]            push_valid;
    logic [NumRequesters-1:0]            push_ready;
    logic [NumRequesters-1:0][Width-1:0] push_data;
    logic [NumRequesters-1:0]            request;
    logic [NumRequesters-1:0]            grant;
    logic                                grant_valid;
    logic [Width-1:0]                    grant_data;
    logic [NumRequesters-1:0]            starve;

    modport master (
        output push_valid, push_data, grant,
        input  push_ready, request, grant_valid, grant_data, starve
    );

    modport slave (
        input  push_valid, push_data, grant,
        output push_ready, request, grant_valid, grant_data, starve
    );
endinterface

// File: rtl/br_arb_req_stage.sv
// rtl/br_arb_req_stage.sv - per-lane request FIFOs that hold request until grant
// Optional starvation counters: define BR_ARB_REQ_STAGE_STARVE_EN.
module br_arb_req_stage #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned Width         = 8,
    parameter int unsigned Depth         = 2,
    parameter int unsigned MaxWait       = 8
) (
    input logic                clk,
    input logic                rst,
    br_arb_req_stage_if.slave  bus
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0]         mem    [NumRequesters][Depth];
    logic [PtrW-1:0]          wr_ptr [NumRequesters];
    logic [PtrW-1:0]          rd_ptr [NumRequesters];
    logic [CntW-1:0]          count  [NumRequesters];
    logic [NumRequesters-1:0] request;
    logic [NumRequesters-1:0] full;
    logic [NumRequesters-1:0] push_acc;
    logic [NumRequesters-1:0] pop;
    logic [Width-1:0]         grant_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // request comes only from registered occupancy, so it cannot drop before its grant
    always_comb begin
        request = '0;
        full    = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            request[i] = (count[i] != '0);
            full[i]    = (count[i] == FullCnt);
        end
        push_acc = bus.push_valid & ~full;
        pop      = bus.grant & request;
    end

    always_comb begin
        grant_data = '0;
        for (int i = NumRequesters - 1; i >= 0; i--) begin
            if (pop[i]) begin
                grant_data = mem[i][rd_ptr[i]];
            end
        end
    end

    assign bus.request     = request;
    assign bus.push_ready  = ~full;
    assign bus.grant_valid = |pop;
    assign bus.grant_data  = grant_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NumRequesters; i++) begin
            if (push_acc[i]) begin
                mem[i][wr_ptr[i]] <= bus.push_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NumRequesters; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumRequesters; i++) begin
                if (push_acc[i]) begin
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                if (push_acc[i] && !pop[i]) begin
                    count[i] <= count[i] + CntW'(1);
                end else if (!push_acc[i] && pop[i]) begin
                    count[i] <= count[i] - CntW'(1);
                end
            end
        end
    end

`ifdef BR_ARB_REQ_STAGE_STARVE_EN
    localparam int unsigned WaitW = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    logic [WaitW-1:0]         wait_cnt [NumRequesters];
    logic [NumRequesters-1:0] starve;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NumRequesters; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRequesters; i++) begin
                if (!request[i] || bus.grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WaitMax) begin
                    wait_cnt[i] <= wait_cnt[i] + WaitW'(1);
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            starve[i] = (wait_cnt[i] == WaitMax);
        end
    end

    assign bus.starve = starve;
`else
    assign bus.starve = '0;
`endif
endmodule
